// File: rtl/br_ram_nr1w_pkg.sv
// Shared helpers for the multi-read-port flop RAM: address sizing and
// per-port slice offsets into the flattened port vectors.
package br_ram_nr1w_pkg;

    // Address width for a given depth, never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Bit offset of port 'port' inside a flattened vector of 'width'-bit slices.
    function automatic int unsigned port_offset(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

    // Bits carried per read-pipeline stage besides valid: data plus uninit flag.
    function automatic int unsigned payload_width(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/br_ram_flops_nr1w_rd_pipe.sv
// Per-port read return delay line: ReadLatency stages of valid, data and
// uninit. Data stages only load when their predecessor is valid, so the
// output holds the last returned value between valid pulses.
module br_ram_flops_nr1w_rd_pipe
    import br_ram_nr1w_pkg::*;
#(
    parameter int Width       = 8,
    parameter int ReadLatency = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [Width-1:0] in_data,
    input  logic             in_uninit,
    output logic             out_valid,
    output logic [Width-1:0] out_data,
    output logic             out_uninit
);

    typedef struct packed {
        logic [Width-1:0] data;
        logic             uninit;
    } payload_t;

    if ($bits(payload_t) != payload_width(Width)) begin : g_bad_payload
        $error("payload layout mismatch");
    end

    if (ReadLatency == 0) begin : g_comb
        assign out_valid  = in_valid;
        assign out_data   = in_data;
        assign out_uninit = in_valid & in_uninit;
    end else begin : g_pipe
        logic     [ReadLatency:0] vld_pipe;
        logic     [ReadLatency:1] vld_pipe_d, vld_pipe_q;
        payload_t [ReadLatency:0] pay_pipe;
        payload_t [ReadLatency:1] pay_d, pay_q;

        // Shift valid every cycle; advance payload only behind a valid bit.
        always_comb begin
            vld_pipe   = {vld_pipe_q, in_valid};
            pay_pipe   = {pay_q, payload_t'{data: in_data, uninit: in_uninit}};
            vld_pipe_d = vld_pipe[ReadLatency-1:0];
            pay_d      = pay_q;
            for (int i = 1; i <= ReadLatency; i++) begin
                if (vld_pipe[i-1]) pay_d[i] = pay_pipe[i-1];
            end
        end

        // Stage registers; reset drops every in-flight read.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_pipe_q <= '0;
                pay_q      <= '0;
            end else begin
                vld_pipe_q <= vld_pipe_d;
                pay_q      <= pay_d;
            end
        end

        assign out_valid  = vld_pipe[ReadLatency];
        assign out_data   = pay_pipe[ReadLatency].data;
        assign out_uninit = vld_pipe[ReadLatency] & pay_pipe[ReadLatency].uninit;
    end

endmodule

// File: rtl/br_ram_flops_nr1w.sv
// Flop RAM, one write port, NumReadPorts independent read ports, each with
// its own latency pipeline and optional same-cycle write bypass.
// Optional macro BR_RAM_FLOPS_NR1W_UNINIT_TRACK_EN adds a per-entry written
// vector that drives rd_uninit; without it rd_uninit is tied to 0.
module br_ram_flops_nr1w
    import br_ram_nr1w_pkg::*;
#(
    parameter  int Depth          = 16,
    parameter  int Width          = 8,
    parameter  int NumReadPorts   = 2,
    parameter  int ReadLatency    = 1,
    parameter  int BypassWrite    = 0,
    parameter  int EnableMemReset = 0,
    localparam int AddrWidth      = int'(addr_width(Depth))
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_valid,
    input  logic [AddrWidth-1:0]              wr_addr,
    input  logic [Width-1:0]                  wr_data,
    input  logic [NumReadPorts-1:0]           rd_addr_valid,
    input  logic [NumReadPorts*AddrWidth-1:0] rd_addr,
    output logic [NumReadPorts-1:0]           rd_data_valid,
    output logic [NumReadPorts*Width-1:0]     rd_data,
    output logic [NumReadPorts-1:0]           rd_uninit
);

    localparam logic [AddrWidth:0] DepthW = (AddrWidth+1)'(Depth);

    logic [Width-1:0] mem_d [Depth];
    logic [Width-1:0] mem_q [Depth];
    logic             wr_in_range;

    assign wr_in_range = ({1'b0, wr_addr} < DepthW);

`ifdef BR_RAM_FLOPS_NR1W_UNINIT_TRACK_EN
    logic [Depth-1:0] written_d, written_q;
`endif

    // Next-state of the array: out-of-range writes are dropped.
    always_comb begin
        mem_d = mem_q;
`ifdef BR_RAM_FLOPS_NR1W_UNINIT_TRACK_EN
        written_d = written_q;
`endif
        if (wr_valid && wr_in_range) begin
            mem_d[wr_addr] = wr_data;
`ifdef BR_RAM_FLOPS_NR1W_UNINIT_TRACK_EN
            written_d[wr_addr] = 1'b1;
`endif
        end
    end

    // Storage; contents survive reset unless EnableMemReset is set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (EnableMemReset != 0) mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef BR_RAM_FLOPS_NR1W_UNINIT_TRACK_EN
    // Written-since-reset tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) written_q <= '0;
        else        written_q <= written_d;
    end
`endif

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_port
        localparam int AOff = int'(port_offset(p, AddrWidth));
        localparam int DOff = int'(port_offset(p, Width));

        logic [AddrWidth-1:0] raddr;
        logic                 rd_in_range;
        logic                 byp_hit;
        logic [Width-1:0]     rdata;
        logic                 runinit;

        assign raddr = rd_addr[AOff +: AddrWidth];

        // Combinational array sample with optional write forwarding.
        always_comb begin
            rd_in_range = ({1'b0, raddr} < DepthW);
            byp_hit     = (BypassWrite != 0) && wr_valid && wr_in_range && (wr_addr == raddr);
            rdata       = '0;
            runinit     = 1'b0;
            if (rd_in_range) rdata = byp_hit ? wr_data : mem_q[raddr];
`ifdef BR_RAM_FLOPS_NR1W_UNINIT_TRACK_EN
            if (!rd_in_range)  runinit = 1'b1;
            else if (!byp_hit) runinit = ~written_q[raddr];
`endif
        end

        br_ram_flops_nr1w_rd_pipe #(
            .Width      (Width),
            .ReadLatency(ReadLatency)
        ) u_rd_pipe (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (rd_addr_valid[p] & rst_n),
            .in_data   (rdata),
            .in_uninit (runinit),
            .out_valid (rd_data_valid[p]),
            .out_data  (rd_data[DOff +: Width]),
            .out_uninit(rd_uninit[p])
        );
    end

endmodule
